// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, default constants and baud helper for the UART receiver
//
// Contents:
//   rx_state_t      receiver FSM states (IDLE, START, DATA, STOP)
//   DEF_CLK_FREQ_HZ default system clock frequency in Hz
//   DEF_BAUD_RATE   default serial bit rate
//   CNT_W           width of the per-bit clock counter (covers 5208 clocks)
//   clks_per_bit()  integer clocks per serial bit (truncating)
package uart_pkg;

    localparam int DEF_CLK_FREQ_HZ = 50_000_000;
    localparam int DEF_BAUD_RATE   = 9600;
    localparam int CNT_W           = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Truncation loses at most one clock per bit; at 50 MHz / 9600 this is
    // 0.33 clock per bit, far inside the UART sampling tolerance.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser for a single asynchronous bit
//
// Parameters:
//   RESET_VAL  value both flops take while i_rst is high
// Ports:
//   i_clk  in   destination clock
//   i_rst  in   synchronous active-high reset
//   i_d    in   asynchronous input
//   o_q    out  synchronised output (two clocks of latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, LSB first, fixed baud, holds last good byte
//
// Parameters:
//   CLK_FREQ_HZ  system clock frequency in Hz
//   BAUD_RATE    serial bit rate
// Ports:
//   clk_50MHz    in   system clock, rising edge
//   SW0          in   synchronous active-high reset
//   UART2_RX     in   asynchronous serial line, idles high
//   data_out     out  last correctly framed byte, held until the next one
//   data_valid   out  one-cycle pulse when data_out is updated
//   frame_error  out  one-cycle pulse when the stop bit is sampled low
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int BAUD_RATE   = DEF_BAUD_RATE
) (
    input  logic       clk_50MHz,
    input  logic       SW0,
    input  logic       UART2_RX,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int HALF         = CLKS_PER_BIT / 2;

    // Terminal counts: the counter runs 0..N-1, so N clocks elapse per period.
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             w_rx_s;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data_out;
    logic             r_data_valid;
    logic             r_frame_error;
    logic             r_rx_prev;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .i_clk (clk_50MHz),
        .i_rst (SW0),
        .i_d   (UART2_RX),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk_50MHz) begin
        if (SW0) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_data_out    <= 8'h00;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            // Starts high so a line already low at reset release is seen as
            // a falling edge only after it has been high at least once more
            // or via the synchroniser's own reset-high value.
            r_rx_prev     <= 1'b1;
        end else begin
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_rx_prev     <= w_rx_s;

            case (r_state)
                IDLE: begin
                    // Edge-triggered so a line stuck low after a framing
                    // error cannot re-arm the receiver repeatedly.
                    if (r_rx_prev && !w_rx_s) begin
                        r_cnt   <= '0;
                        r_state <= START;
                    end
                end

                START: begin
                    if (r_cnt == LAST_HALF) begin
                        if (w_rx_s) begin
                            // Line went back high before mid-start: glitch.
                            r_state <= IDLE;
                        end else begin
                            r_cnt     <= '0;
                            r_bit_idx <= '0;
                            r_state   <= DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    // Aligned to mid-start, so every full period lands mid-bit.
                    if (r_cnt == LAST_BIT) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                STOP: begin
                    // Leaving at mid-stop leaves half a bit to catch the
                    // next start edge of a back-to-back frame.
                    if (r_cnt == LAST_BIT) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (w_rx_s) begin
                            r_data_out   <= r_shift;
                            r_data_valid <= 1'b1;
                        end else begin
                            r_frame_error <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign frame_error = r_frame_error;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking randomized bench for uart_rx against a frame-level model
module tb_uart_rx;

    // Scaled clock/baud keeps the run short; 17 clocks per bit gives an odd
    // bit period so the half-bit truncation is exercised too.
    localparam int CLK_HZ  = 17_000_000;
    localparam int BAUD    = 1_000_000;
    localparam int C       = CLK_HZ / BAUD;
    localparam int HALF    = C / 2;
    localparam int LAT_NOM = (19 * C) / 2;
    localparam int LAT_MIN = LAT_NOM + 1;
    localparam int LAT_MAX = LAT_NOM + 5;

    logic       clk = 1'b0;
    logic       sw0 = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         n_valid = 0;
    int         n_fe = 0;
    int         last_lat = 0;
    int         t_start = 0;
    int         n_bad_chg = 0;
    logic [7:0] prev_do = 8'h00;
    logic       sw0_edge = 1'b1;
    logic [7:0] model_do = 8'h00;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD)
    ) dut (
        .clk_50MHz   (clk),
        .SW0         (sw0),
        .UART2_RX    (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_error (frame_error)
    );

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        sw0_edge <= sw0;
    end

    // Pulse counters and a watch on data_out changing without a valid pulse.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            n_valid  = n_valid + 1;
            last_lat = cyc - t_start;
        end
        if (frame_error === 1'b1) n_fe = n_fe + 1;
        if (data_out !== prev_do && data_valid !== 1'b1 && !sw0_edge)
            n_bad_chg = n_bad_chg + 1;
        prev_do = data_out;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Sends one full frame and checks the frame-level outcome at its end.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        int v0;
        int f0;
        v0 = n_valid;
        f0 = n_fe;
        t_start = cyc;
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk);
        end
        rx = stop_ok;
        repeat (C) @(negedge clk);
        if (stop_ok) model_do = b;
        check_eq("valid_pulses", n_valid - v0, stop_ok ? 1 : 0);
        check_eq("frame_err_pulses", n_fe - f0, stop_ok ? 0 : 1);
        check_eq("data_out", {24'h0, data_out}, {24'h0, model_do});
        if (stop_ok)
            check_eq("latency_in_window", (last_lat >= LAT_MIN && last_lat <= LAT_MAX) ? 1 : 0, 1);
    endtask

    initial begin
        int v0;
        int f0;
        logic [7:0] b;
        logic ok;
        logic prev_fe;
        int gap;

        // Reset with the line idle.
        repeat (10) @(negedge clk);
        check_eq("rst_data_out", {24'h0, data_out}, 32'h0);
        check_eq("rst_valid", {31'h0, data_valid}, 32'h0);
        check_eq("rst_frame_err", {31'h0, frame_error}, 32'h0);
        sw0 = 1'b0;
        idle(20 * C);
        check_eq("idle_valid_cnt", n_valid, 0);
        check_eq("idle_fe_cnt", n_fe, 0);
        check_eq("idle_data_out", {24'h0, data_out}, 32'h0);

        // Single frame, then gap, repeat, then back-to-back frames.
        send_frame(8'h4A, 1'b1);
        idle(2 * C);
        send_frame(8'h4A, 1'b1);
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        idle(C);

        // Framing error, then the line stays low: no re-trigger allowed.
        send_frame(8'h3C, 1'b0);
        v0 = n_valid;
        f0 = n_fe;
        rx = 1'b0;
        repeat (3 * C) @(negedge clk);
        idle(2 * C);
        check_eq("held_low_valid", n_valid - v0, 0);
        check_eq("held_low_fe", n_fe - f0, 0);
        check_eq("held_low_data_out", {24'h0, data_out}, {24'h0, model_do});

        // Short low glitch on an idle line.
        v0 = n_valid;
        f0 = n_fe;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(3 * C);
        check_eq("glitch_valid", n_valid - v0, 0);
        check_eq("glitch_fe", n_fe - f0, 0);
        check_eq("glitch_data_out", {24'h0, data_out}, {24'h0, model_do});
        send_frame(8'h81, 1'b1);
        idle(C);

        // Reset in the middle of bit 4 (bit 4 of 0x5A is 1, so releasing
        // reset with the line high leaves no falling edge behind).
        v0 = n_valid;
        f0 = n_fe;
        b = 8'h5A;
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk);
        end
        rx = b[4];
        repeat (HALF) @(negedge clk);
        sw0 = 1'b1;
        @(negedge clk);
        check_eq("midrst_data_out", {24'h0, data_out}, 32'h0);
        check_eq("midrst_valid", {31'h0, data_valid}, 32'h0);
        sw0 = 1'b0;
        model_do = 8'h00;
        idle(12 * C);
        check_eq("midrst_valid_cnt", n_valid - v0, 0);
        check_eq("midrst_fe_cnt", n_fe - f0, 0);
        send_frame(8'hC7, 1'b1);

        // Randomized frames, gaps, framing errors and glitches.
        prev_fe = 1'b0;
        for (int k = 0; k < 24; k++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            if (prev_fe)
                gap = $urandom_range(2 * C, 3 * C);
            else if ($urandom_range(0, 2) == 0)
                gap = 0;
            else
                gap = $urandom_range(1, 3 * C);
            if (gap >= 2 * C && $urandom_range(0, 1) == 1) begin
                idle(C / 2);
                rx = 1'b0;
                repeat ($urandom_range(1, HALF - 2)) @(negedge clk);
                idle(2 * C);
            end else if (gap > 0) begin
                idle(gap);
            end
            send_frame(b, ok);
            prev_fe = !ok;
        end
        idle(2 * C);

        check_eq("no_unexpected_data_out_change", n_bad_chg, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver running on the 50 MHz system clock.
- Deserialises the asynchronous serial line UART2_RX (LSB first, 1 start bit, 8 data bits, 1 stop bit, no parity) at a fixed baud rate.
- Holds the last correctly framed byte on data_out.
- Sits between the board UART2 pin and the computer's I/O logic.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD_RATE (5208), integer clocks per bit. Derived; not intended to be overridden.

Ports:
- clk_50MHz  in  1  system clock; all logic is on the rising edge.
- SW0  in  1  synchronous, active-high reset.
- UART2_RX  in  1  asynchronous serial input; idles high.
- data_out  out  8  last received byte, held until the next valid frame.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- frame_error  out  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Input synchronisation:
  - UART2_RX passes through a 2-flop synchroniser (rx_s) before any use.
  - Both synchroniser flops reset to 1.
- Reset (SW0=1 at a clock edge):
  - State goes to IDLE; counters go to 0.
  - data_out=8'h00, data_valid=0, frame_error=0.
  - Reset mid-frame aborts the frame with no output update.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Wait for rx_s=0.
  - On rx_s=0: clear the clock counter and go to START.
- START:
  - Count HALF = CLKS_PER_BIT/2 (2604) clocks.
  - At the half point, resample rx_s.
  - If rx_s=1: false start (glitch); return to IDLE.
  - If rx_s=0: clear the counter, set bit_idx=0, go to DATA.
- DATA:
  - Every CLKS_PER_BIT clocks, sample rx_s into shift register bit bit_idx (LSB first), at the mid-bit point.
  - After bit_idx=7 is sampled, go to STOP.
- STOP:
  - After CLKS_PER_BIT clocks, sample rx_s.
  - If rx_s=1: data_out <= shift register and data_valid pulses for exactly one cycle.
  - If rx_s=0: data_out is unchanged and frame_error pulses for one cycle.
  - Either way, return to IDLE immediately.
  - Back-to-back frames are accepted because the return to IDLE happens at mid-stop-bit.
- Latency: data_out updates about 9.5 bit periods after the start falling edge, plus 2–3 clocks for synchronisation and registration.
- Counter width: 13 bits, sufficient for 5208.
- Baud error: 0.33 clock per bit of truncation is acceptable (<0.01%).
- Held input: a line held low after a framing error re-triggers START only once rx_s goes high then low again. IDLE requires a falling edge: track the previous rx_s value and trigger on prev=1, cur=0.
- data_out is registered and only ever changes on valid frames.

Decomposition:
- Package uart_pkg:
  - state enum rx_state_t {IDLE, START, DATA, STOP}.
  - Default clock and baud constants.
  - Function clks_per_bit(clk, baud).
- One natural sub-module: sync_2ff (generic 2-flop synchroniser with reset value parameter). The FSM, counters and shift register stay in uart_rx.

Test Plan:
- Idle hold:
  - Stimulus: SW0=1 for 100 us with line high, then release.
  - Required response: data_out=8'h00; no data_valid or frame_error for 200 us idle.
- Single frame:
  - Stimulus: at t=300 us send 0x4A ('J'): bits 0,1,0,1,0,0,1,0 LSB-first at 104.167 us per bit, stop=1.
  - Required response: data_out=8'h4A and one data_valid pulse at about 1290 us (±3 clocks).
- Back-to-back:
  - Stimulus: 200 us idle, then a second 0x4A frame.
  - Required response: second data_valid pulse; data_out stays 8'h4A. Then send 0x55, then 0xA3 with no idle gap.
  - Required response: data_out=8'h55, then 8'hA3.
- Framing error:
  - Stimulus: send 0x3C with the stop bit held 0.
  - Required response: frame_error pulse; data_out keeps its previous value; no data_valid.
- Glitch rejection:
  - Stimulus: a 20 µs low pulse on the idle line.
  - Required response: FSM returns to IDLE; no pulses; data_out unchanged.
- Reset mid-frame:
  - Stimulus: assert SW0 during bit 4 of a frame.
  - Required response: data_out=8'h00 next clock; no data_valid; the next full frame is received correctly.
